// File: rtl/axis_tap_fifo.sv
// Passive AXI-stream tap feeding a frame-aware FIFO that replays snooped frames on m_axis.
// Frames that do not fit are truncated (flagged via tuser) or dropped, with pulses and saturating counters.
module axis_tap_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit ID_ENABLE = 0,
  parameter int ID_WIDTH = 8,
  parameter bit DEST_ENABLE = 0,
  parameter int DEST_WIDTH = 8,
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK = 1'b1,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    tap_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    tap_axis_tkeep,
  input  logic                     tap_axis_tvalid,
  input  logic                     tap_axis_tready,
  input  logic                     tap_axis_tlast,
  input  logic [ID_WIDTH-1:0]      tap_axis_tid,
  input  logic [DEST_WIDTH-1:0]    tap_axis_tdest,
  input  logic [USER_WIDTH-1:0]    tap_axis_tuser,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [ID_WIDTH-1:0]      m_axis_tid,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic [$clog2(DEPTH):0]   status_fifo_count,
  output logic                     status_frame_truncated,
  output logic                     status_frame_dropped,
  output logic [CNT_WIDTH-1:0]     status_trunc_count,
  output logic [CNT_WIDTH-1:0]     status_drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_nxt, count;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          cap, full, room2, rd_en, wr_en, trunc, drop;
  logic          last_w;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [USER_WIDTH-1:0] mark_bad(input logic [USER_WIDTH-1:0] u);
    return (u & ~USER_BAD_FRAME_MASK) | (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);
  endfunction

  assign cap        = tap_axis_tvalid & tap_axis_tready;
  assign count      = wr_ptr - rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign room2      = count <= (AW+1)'(DEPTH - 2);
  assign rd_en      = m_axis_tvalid & m_axis_tready;
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_en};
  assign wr_addr    = wr_ptr[AW-1:0];
  assign rd_addr    = rd_ptr_nxt[AW-1:0];
  assign last_w     = tap_axis_tlast | trunc;

  assign status_fifo_count = count;

  // Room checks use the pre-edge count; a concurrent read does not free space this cycle.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trunc     = 1'b0;
    drop      = 1'b0;
    if (cap) begin
      case (state)
        IDLE: begin
          if (tap_axis_tlast) begin
            if (!full) wr_en = 1'b1;
            else       drop  = 1'b1;
          end else if (room2) begin
            wr_en     = 1'b1;
            state_nxt = ACTIVE;
          end else begin
            drop      = 1'b1;
            state_nxt = DROP;
          end
        end
        ACTIVE: begin
          wr_en = 1'b1;
          if (tap_axis_tlast) begin
            state_nxt = IDLE;
          end else if (!room2) begin
            trunc     = 1'b1;
            state_nxt = DROP;
          end
        end
        DROP: begin
          if (tap_axis_tlast) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control stage: frame state, pointers, output valid and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      m_axis_tvalid          <= 1'b0;
      status_frame_truncated <= 1'b0;
      status_frame_dropped   <= 1'b0;
      status_trunc_count     <= '0;
      status_drop_count      <= '0;
    end else begin
      state                  <= state_nxt;
      rd_ptr                 <= rd_ptr_nxt;
      if (wr_en) wr_ptr      <= wr_ptr + {{AW{1'b0}}, 1'b1};
      m_axis_tvalid          <= (wr_ptr != rd_ptr_nxt);
      status_frame_truncated <= trunc;
      status_frame_dropped   <= drop;
      if (trunc) status_trunc_count <= sat_inc(status_trunc_count);
      if (drop)  status_drop_count  <= sat_inc(status_drop_count);
    end
  end

  // Data stage: storage plus an output register that tracks the head entry.
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_addr] <= tap_axis_tdata;
      mem_last[wr_addr] <= last_w;
    end
    m_axis_tdata <= mem_data[rd_addr];
    m_axis_tlast <= mem_last[rd_addr];
  end

  generate
    if (KEEP_ENABLE) begin : g_keep
      logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) mem_keep[wr_addr] <= tap_axis_tkeep;
        m_axis_tkeep <= mem_keep[rd_addr];
      end
    end else begin : g_no_keep
      logic unused_keep;
      assign unused_keep  = ^tap_axis_tkeep;
      assign m_axis_tkeep = '1;
    end

    if (ID_ENABLE) begin : g_id
      logic [ID_WIDTH-1:0] mem_id [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) mem_id[wr_addr] <= tap_axis_tid;
        m_axis_tid <= mem_id[rd_addr];
      end
    end else begin : g_no_id
      logic unused_id;
      assign unused_id  = ^tap_axis_tid;
      assign m_axis_tid = '0;
    end

    if (DEST_ENABLE) begin : g_dest
      logic [DEST_WIDTH-1:0] mem_dest [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) mem_dest[wr_addr] <= tap_axis_tdest;
        m_axis_tdest <= mem_dest[rd_addr];
      end
    end else begin : g_no_dest
      logic unused_dest;
      assign unused_dest  = ^tap_axis_tdest;
      assign m_axis_tdest = '0;
    end

    if (USER_ENABLE) begin : g_user
      logic [USER_WIDTH-1:0] mem_user [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) mem_user[wr_addr] <= trunc ? mark_bad(tap_axis_tuser) : tap_axis_tuser;
        m_axis_tuser <= mem_user[rd_addr];
      end
    end else begin : g_no_user
      logic unused_user;
      assign unused_user  = ^tap_axis_tuser;
      assign m_axis_tuser = '0;
    end
  endgenerate

endmodule

// File: tb/tb_axis_tap_fifo.sv
// Bench for axis_tap_fifo: directed frame scenarios plus random traffic,
// compared every cycle against a queue-based model of the stored beats.
module tb_axis_tap_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tap_axis_tdata;
  logic [7:0]  tap_axis_tkeep;
  logic        tap_axis_tvalid, tap_axis_tready, tap_axis_tlast;
  logic [7:0]  tap_axis_tid, tap_axis_tdest;
  logic [0:0]  tap_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tid, m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [4:0]  status_fifo_count;
  logic        status_frame_truncated, status_frame_dropped;
  logic [15:0] status_trunc_count, status_drop_count;

  axis_tap_fifo #(.DATA_WIDTH(64), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .tap_axis_tdata(tap_axis_tdata), .tap_axis_tkeep(tap_axis_tkeep),
    .tap_axis_tvalid(tap_axis_tvalid), .tap_axis_tready(tap_axis_tready),
    .tap_axis_tlast(tap_axis_tlast), .tap_axis_tid(tap_axis_tid),
    .tap_axis_tdest(tap_axis_tdest), .tap_axis_tuser(tap_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .status_fifo_count(status_fifo_count),
    .status_frame_truncated(status_frame_truncated),
    .status_frame_dropped(status_frame_dropped),
    .status_trunc_count(status_trunc_count),
    .status_drop_count(status_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  localparam int M_IDLE = 0, M_IN_FRAME = 1, M_DISCARD = 2;

  beat_t q[$];
  int    mode;
  bit    exp_valid, exp_tp, exp_dp;
  int    exp_tc, exp_dc;
  int    n_total, n_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = M_IDLE;
    exp_valid = 0; exp_tp = 0; exp_dp = 0; exp_tc = 0; exp_dc = 0;
  endtask

  // Applies the frame-admission rules to the beat presented this cycle.
  task automatic model_edge(input logic mr);
    int    free;
    bit    wr, trn, drp, tl;
    int    nvis;
    beat_t b;
    free = DEPTH - q.size();
    tl = tap_axis_tlast;
    wr = 0; trn = 0; drp = 0;
    if (tap_axis_tvalid && tap_axis_tready) begin
      if (mode == M_IDLE) begin
        if (tl) begin
          if (free >= 1) wr = 1; else drp = 1;
        end else if (free >= 2) begin
          wr = 1; mode = M_IN_FRAME;
        end else begin
          drp = 1; mode = M_DISCARD;
        end
      end else if (mode == M_IN_FRAME) begin
        wr = 1;
        if (tl) mode = M_IDLE;
        else if (free < 2) begin trn = 1; mode = M_DISCARD; end
      end else begin
        if (tl) mode = M_IDLE;
      end
    end
    if (exp_valid && mr) void'(q.pop_front());
    nvis = q.size();
    if (wr) begin
      b.d = tap_axis_tdata; b.k = tap_axis_tkeep;
      b.l = tl | trn;       b.u = trn ? 1'b1 : tap_axis_tuser[0];
      q.push_back(b);
    end
    exp_valid = (nvis > 0);
    exp_tp = trn;
    exp_dp = drp;
    if (trn && exp_tc < 65535) exp_tc++;
    if (drp && exp_dc < 65535) exp_dc++;
  endtask

  task automatic check_outputs();
    check_val("m_valid", m_axis_tvalid, exp_valid);
    if (exp_valid) begin
      check_val("m_data", m_axis_tdata, q[0].d);
      check_val("m_keep", m_axis_tkeep, q[0].k);
      check_val("m_last", m_axis_tlast, q[0].l);
      check_val("m_user", m_axis_tuser, q[0].u);
    end
    check_val("m_tid", m_axis_tid, 0);
    check_val("m_tdest", m_axis_tdest, 0);
    check_val("fifo_count", status_fifo_count, q.size());
    check_val("trunc_pulse", status_frame_truncated, exp_tp);
    check_val("drop_pulse", status_frame_dropped, exp_dp);
    check_val("trunc_count", status_trunc_count, exp_tc);
    check_val("drop_count", status_drop_count, exp_dc);
  endtask

  // One clock: drive at the falling edge, update model, check at the next falling edge.
  task automatic cycle(input logic tv, input logic tr, input logic tl,
                       input logic [63:0] d, input logic [7:0] k, input logic u,
                       input logic mr);
    tap_axis_tvalid = tv; tap_axis_tready = tr; tap_axis_tlast = tl;
    tap_axis_tdata = d;   tap_axis_tkeep = k;   tap_axis_tuser = u;
    tap_axis_tid = 8'($urandom); tap_axis_tdest = 8'($urandom);
    m_axis_tready = mr;
    model_edge(mr);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 64'h0, 8'h0, 0, mr);
  endtask

  task automatic send_frame(input int len, input logic mr, input bit pattern);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      d = pattern ? 64'h1111_1111_1111_1111 * (i + 1) : {$urandom, $urandom};
      cycle(1, 1, i == len - 1, d, pattern ? 8'hFF : 8'($urandom), 0, mr);
    end
  endtask

  initial begin
    int left, phase_mr;
    logic tv, tr, mr;
    n_total = 0; n_bad = 0;
    rst = 1;
    tap_axis_tvalid = 0; tap_axis_tready = 0; tap_axis_tlast = 0;
    tap_axis_tdata = 0; tap_axis_tkeep = 0; tap_axis_tuser = 0;
    tap_axis_tid = 0; tap_axis_tdest = 0; m_axis_tready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 0;

    // Basic replay of a 3-beat frame
    send_frame(3, 1, 1);
    idle(4, 1);

    // Truncation of a 20-beat frame into an empty FIFO with a stalled sink
    send_frame(20, 0, 0);
    check_val("trunc_total", status_trunc_count, 1);
    check_val("trunc_fill", status_fifo_count, 16);

    // Full drop of a 2-beat then a 1-beat frame
    send_frame(2, 0, 0);
    send_frame(1, 0, 0);
    check_val("drop_total", status_drop_count, 2);

    // Recovery: drain then a clean 4-beat frame
    idle(3, 1);
    send_frame(4, 1, 0);
    idle(24, 1);
    check_val("drained", status_fifo_count, 0);

    // Concurrent read at count 14, then truncation at count 15
    send_frame(14, 0, 0);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hFF, 0, 1);
    check_val("bnd_count14", status_fifo_count, 14);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hFF, 0, 0);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hFF, 0, 0);
    check_val("bnd_trunc", status_trunc_count, 2);
    cycle(1, 1, 1, {$urandom, $urandom}, 8'hFF, 0, 0);
    idle(20, 1);

    // Random traffic with changing sink behaviour
    left = $urandom_range(1, 24);
    phase_mr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) phase_mr = $urandom_range(0, 2);
      tv = ($urandom_range(0, 9) < 7);
      tr = ($urandom_range(0, 9) < 8);
      mr = (phase_mr == 0) ? 1'b1 : (phase_mr == 1) ? 1'($urandom) : 1'b0;
      cycle(tv, tr, left == 1, {$urandom, $urandom}, 8'($urandom),
            ($urandom_range(0, 7) == 0), mr);
      if (tv && tr) begin
        left--;
        if (left == 0) left = $urandom_range(1, 24);
      end
    end

    // Reset during beat 2 of a 5-beat frame
    idle(2, 0);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hFF, 0, 0);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hFF, 0, 0);
    tap_axis_tvalid = 1; tap_axis_tready = 1; tap_axis_tlast = 0;
    #2 rst = 1;
    #1;
    check_val("rst_valid", m_axis_tvalid, 0);
    check_val("rst_trunc_cnt", status_trunc_count, 0);
    check_val("rst_drop_cnt", status_drop_count, 0);
    check_val("rst_count", status_fifo_count, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_outputs();
    cycle(1, 1, 0, {$urandom, $urandom}, 8'h0F, 1, 0);
    cycle(1, 1, 0, {$urandom, $urandom}, 8'hF0, 0, 0);
    cycle(1, 1, 1, {$urandom, $urandom}, 8'h3C, 1, 0);
    check_val("frag_count", status_fifo_count, 3);
    idle(8, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
